// File: rtl/serial_add_sub_if.sv
// Handshake and data bundle for the bit-serial adder/subtractor.
// Ports: operand side in_valid/in_ready/a/b/c_in/sub.
//        Result side out_valid/out_ready/sum/c_out/overflow.
// master = producer/consumer environment, slave = serial_add_sub.
interface serial_add_sub_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             overflow;

  modport master (
    output in_valid, a, b, c_in, sub, out_ready,
    input  in_ready, out_valid, sum, c_out, overflow
  );

  modport slave (
    input  in_valid, a, b, c_in, sub, out_ready,
    output in_ready, out_valid, sum, c_out, overflow
  );
endinterface

// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flop, LSB first.
// Latency: accept at edge k -> out_valid after edge k+WIDTH; at most 1 result per WIDTH+2 cycles.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready.
// Ports: clk, rst_n (sync active-low), io (slave modport of serial_add_sub_if), busy (BUSY or DONE).
module serial_add_sub #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  serial_add_sub_if.slave       io,
  output logic                  busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] sum_sh;
  logic [WIDTH-1:0] sum_q;
  logic             carry;
  logic             c_out_q;
  logic             ovf_q;
  logic [CW-1:0]    cnt;

  logic             s_bit;
  logic             carry_nxt;
  logic [WIDTH-1:0] sum_nxt;
  logic             last_step;

  // Single full-adder cell; the new sum bit enters at the MSB end so that
  // after WIDTH steps the LSB-first stream lines up as a normal word.
  always_comb begin
    s_bit     = a_sh[0] ^ b_sh[0] ^ carry;
    carry_nxt = (a_sh[0] & b_sh[0]) | (a_sh[0] & carry) | (b_sh[0] & carry);
    sum_nxt   = sum_sh >> 1;
    sum_nxt[WIDTH-1] = s_bit;
    last_step = (cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      sum_sh  <= '0;
      sum_q   <= '0;
      carry   <= 1'b0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      cnt     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (io.in_valid) begin
            // Subtract is A + ~B + 1: invert B here and seed the carry with 1.
            a_sh  <= io.a;
            b_sh  <= io.sub ? ~io.b : io.b;
            carry <= io.sub ? 1'b1 : io.c_in;
            cnt   <= '0;
            state <= S_BUSY;
          end
        end
        S_BUSY: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          sum_sh <= sum_nxt;
          carry  <= carry_nxt;
          cnt    <= cnt + CW'(1);
          if (last_step) begin
            // On the MSB step 'carry' is the carry into the MSB and
            // carry_nxt the carry out; their XOR is signed overflow.
            sum_q   <= sum_nxt;
            c_out_q <= carry_nxt;
            ovf_q   <= carry ^ carry_nxt;
            state   <= S_DONE;
          end
        end
        S_DONE: begin
          if (io.out_ready) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign io.in_ready  = (state == S_IDLE);
  assign io.out_valid = (state == S_DONE);
  assign busy         = (state == S_BUSY) || (state == S_DONE);
  assign io.sum       = sum_q;
  assign io.c_out     = c_out_q;
  assign io.overflow  = ovf_q;

endmodule

// File: tb/tb_serial_add_sub.sv
// Directed and exhaustive checks of serial_add_sub for WIDTH=8, 3 and 1.
// Expected results are queued at operand accept and popped when the result appears.
module tb_serial_add_sub;

  logic clk = 1'b0;
  logic rst_n;
  logic busy8, busy3, busy1;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  logic [65:0] q8[$];
  logic [65:0] q3[$];
  logic [65:0] q1[$];

  serial_add_sub_if #(.WIDTH(8)) i8 ();
  serial_add_sub_if #(.WIDTH(3)) i3 ();
  serial_add_sub_if #(.WIDTH(1)) i1 ();

  serial_add_sub #(.WIDTH(8)) dut8 (.clk(clk), .rst_n(rst_n), .io(i8), .busy(busy8));
  serial_add_sub #(.WIDTH(3)) dut3 (.clk(clk), .rst_n(rst_n), .io(i3), .busy(busy3));
  serial_add_sub #(.WIDTH(1)) dut1 (.clk(clk), .rst_n(rst_n), .io(i1), .busy(busy1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: returns {overflow, c_out, sum (masked to w bits)}.
  function automatic logic [65:0] ref_model(input int w, input logic [63:0] a,
                                            input logic [63:0] b, input logic c,
                                            input logic s);
    logic [63:0] mask, bb, sm;
    logic [64:0] full;
    logic        co, ov;
    mask = (64'd1 << w) - 64'd1;
    bb   = (s ? ~b : b) & mask;
    full = {1'b0, a & mask} + {1'b0, bb} + {64'd0, (s ? 1'b1 : c)};
    sm   = full[63:0] & mask;
    co   = full[w];
    ov   = (a[w-1] == bb[w-1]) && (sm[w-1] != a[w-1]);
    return {ov, co, sm};
  endfunction

  // One WIDTH=8 operation with spec-given expected results and hold cycles of backpressure.
  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                     input logic c, input logic s, input logic [7:0] es,
                     input logic ec, input logic ev, input int hold);
    int lat;
    logic [65:0] e;
    i8.a = a; i8.b = b; i8.c_in = c; i8.sub = s;
    i8.in_valid = 1'b1; i8.out_ready = 1'b0;
    chk({tag, "_in_ready"}, 64'(i8.in_ready), 64'd1);
    @(posedge clk); #1;
    i8.in_valid = 1'b0;
    q8.push_back({ev, ec, 56'd0, es});
    lat = 0;
    while (!i8.out_valid && lat < 40) begin
      chk({tag, "_busy"}, 64'(busy8), 64'd1);
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'd8);
    chk({tag, "_done_busy"}, 64'(busy8), 64'd1);
    chk({tag, "_done_in_ready"}, 64'(i8.in_ready), 64'd0);
    chk({tag, "_sb_nonempty"}, 64'(q8.size()), 64'd1);
    e = (q8.size() > 0) ? q8.pop_front() : '0;
    chk({tag, "_sum"}, 64'(i8.sum), e[63:0]);
    chk({tag, "_c_out"}, 64'(i8.c_out), 64'(e[64]));
    chk({tag, "_overflow"}, 64'(i8.overflow), 64'(e[65]));
    for (int h = 0; h < hold; h++) begin
      i8.in_valid = 1'($urandom_range(0, 1));
      i8.a = 8'($urandom);
      i8.b = 8'($urandom);
      @(posedge clk); #1;
      chk({tag, "_hold_valid"}, 64'(i8.out_valid), 64'd1);
      chk({tag, "_hold_in_ready"}, 64'(i8.in_ready), 64'd0);
      chk({tag, "_hold_sum"}, 64'(i8.sum), e[63:0]);
      chk({tag, "_hold_flags"}, 64'({i8.c_out, i8.overflow}), 64'({e[64], e[65]}));
    end
    i8.in_valid = 1'b0;
    i8.out_ready = 1'b1;
    @(posedge clk); #1;
    i8.out_ready = 1'b0;
    chk({tag, "_post_valid"}, 64'(i8.out_valid), 64'd0);
    chk({tag, "_post_in_ready"}, 64'(i8.in_ready), 64'd1);
    chk({tag, "_post_busy"}, 64'(busy8), 64'd0);
    chk({tag, "_post_sum_kept"}, 64'(i8.sum), e[63:0]);
  endtask

  task automatic exh3();
    int last_acc, acc, exp_sp, lat, dc;
    logic r;
    logic [65:0] e;
    last_acc = -1;
    exp_sp = 0;
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++)
        for (int c = 0; c < 2; c++)
          for (int s = 0; s < 2; s++) begin
            i3.a = 3'(a); i3.b = 3'(b); i3.c_in = 1'(c); i3.sub = 1'(s);
            i3.in_valid = 1'b1;
            chk("w3_in_ready", 64'(i3.in_ready), 64'd1);
            @(posedge clk); #1;
            i3.in_valid = 1'b0;
            acc = cyc;
            q3.push_back(ref_model(3, 64'(a), 64'(b), 1'(c), 1'(s)));
            if (last_acc >= 0) chk("w3_spacing", 64'(acc - last_acc), 64'(exp_sp));
            last_acc = acc;
            lat = 0;
            while (!i3.out_valid && lat < 20) begin
              @(posedge clk); #1;
              lat++;
            end
            chk("w3_latency", 64'(lat), 64'd3);
            e = (q3.size() > 0) ? q3.pop_front() : '0;
            chk("w3_sum", 64'(i3.sum), e[63:0]);
            chk("w3_flags", 64'({i3.c_out, i3.overflow}), 64'({e[64], e[65]}));
            dc = 0;
            do begin
              r = 1'($urandom_range(0, 1));
              i3.out_ready = r;
              @(posedge clk); #1;
              dc++;
              if (!r) chk("w3_hold_sum", 64'(i3.sum), e[63:0]);
            end while (!r && dc < 50);
            i3.out_ready = 1'b0;
            chk("w3_released", 64'(i3.out_valid), 64'd0);
            exp_sp = 3 + dc + 1;
          end
  endtask

  task automatic exh1();
    int last_acc, acc, exp_sp, lat, dc;
    logic r;
    logic [65:0] e;
    last_acc = -1;
    exp_sp = 0;
    for (int a = 0; a < 2; a++)
      for (int b = 0; b < 2; b++)
        for (int c = 0; c < 2; c++)
          for (int s = 0; s < 2; s++) begin
            i1.a = 1'(a); i1.b = 1'(b); i1.c_in = 1'(c); i1.sub = 1'(s);
            i1.in_valid = 1'b1;
            chk("w1_in_ready", 64'(i1.in_ready), 64'd1);
            @(posedge clk); #1;
            i1.in_valid = 1'b0;
            acc = cyc;
            q1.push_back(ref_model(1, 64'(a), 64'(b), 1'(c), 1'(s)));
            if (last_acc >= 0) chk("w1_spacing", 64'(acc - last_acc), 64'(exp_sp));
            last_acc = acc;
            lat = 0;
            while (!i1.out_valid && lat < 20) begin
              @(posedge clk); #1;
              lat++;
            end
            chk("w1_latency", 64'(lat), 64'd1);
            e = (q1.size() > 0) ? q1.pop_front() : '0;
            chk("w1_sum", 64'(i1.sum), e[63:0]);
            chk("w1_flags", 64'({i1.c_out, i1.overflow}), 64'({e[64], e[65]}));
            dc = 0;
            do begin
              r = 1'($urandom_range(0, 1));
              i1.out_ready = r;
              @(posedge clk); #1;
              dc++;
            end while (!r && dc < 50);
            i1.out_ready = 1'b0;
            chk("w1_released", 64'(i1.out_valid), 64'd0);
            exp_sp = 1 + dc + 1;
          end
  endtask

  initial begin
    int seen;
    rst_n = 1'b0;
    i8.in_valid = 1'b0; i8.a = '0; i8.b = '0; i8.c_in = 1'b0; i8.sub = 1'b0; i8.out_ready = 1'b0;
    i3.in_valid = 1'b0; i3.a = '0; i3.b = '0; i3.c_in = 1'b0; i3.sub = 1'b0; i3.out_ready = 1'b0;
    i1.in_valid = 1'b0; i1.a = '0; i1.b = '0; i1.c_in = 1'b0; i1.sub = 1'b0; i1.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 64'(i8.in_ready), 64'd1);
    chk("rst_out_valid", 64'(i8.out_valid), 64'd0);
    chk("rst_busy", 64'(busy8), 64'd0);
    chk("rst_sum", 64'(i8.sum), 64'd0);
    chk("rst_flags", 64'({i8.c_out, i8.overflow}), 64'd0);
    rst_n = 1'b1;

    op8("add_5a_33", 8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0, 1'b1, 0);
    op8("add_ff_00_ci1", 8'hFF, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 0);
    op8("add_ff_00_ci0", 8'hFF, 8'h00, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 0);
    op8("sub_10_20", 8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0, 0);
    op8("sub_80_01_ci1", 8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1, 0);
    op8("sub_10_20_ci1", 8'h10, 8'h20, 1'b1, 1'b1, 8'hF0, 1'b0, 1'b0, 0);
    op8("bp_add_7f_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 5);
    op8("after_bp_sub", 8'h0F, 8'h0F, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 0);

    // Reset asserted for the edge that ends the third BUSY cycle.
    i8.a = 8'h3C; i8.b = 8'h55; i8.c_in = 1'b1; i8.sub = 1'b0; i8.in_valid = 1'b1;
    @(posedge clk); #1;
    i8.in_valid = 1'b0;
    i8.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_rst_busy_before", 64'(busy8), 64'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mid_rst_in_ready", 64'(i8.in_ready), 64'd1);
    chk("mid_rst_busy", 64'(busy8), 64'd0);
    chk("mid_rst_sum", 64'(i8.sum), 64'd0);
    chk("mid_rst_flags", 64'({i8.c_out, i8.overflow}), 64'd0);
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      if (i8.out_valid) seen++;
      @(posedge clk); #1;
    end
    chk("mid_rst_no_valid", 64'(seen), 64'd0);
    i8.out_ready = 1'b0;
    op8("post_rst_add", 8'h01, 8'h01, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 0);

    exh3();
    exh1();

    chk("sb8_empty", 64'(q8.size()), 64'd0);
    chk("sb3_empty", 64'(q3.size()), 64'd0);
    chk("sb1_empty", 64'(q1.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
